// File: rtl/imem_loader.sv
// Packs UART bytes (first byte MSB) into words and writes them to the instruction RAM
// until the HALT word. Optional byte checksum after HALT: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int         RAM_WIDTH   = 32,
  parameter int         RAM_DEPTH   = 2048,
  parameter int         BYTE_WIDTH  = 8,
  parameter logic [5:0] HALT_OPCODE = 6'b111111,
  localparam int        CW          = $clog2(RAM_DEPTH) + 1
) (
  input  logic                  clka,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BYTE_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic [RAM_WIDTH-1:0]  addra,
  output logic [RAM_WIDTH-1:0]  dina,
  output logic                  wea,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CW-1:0]         word_count
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, RECV = 3'd1, SETUP = 3'd2, WRITE = 3'd3, HOLD = 3'd4, CHECK = 3'd5, DONE = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, RECV = 3'd1, SETUP = 3'd2, WRITE = 3'd3, HOLD = 3'd4, DONE = 3'd6
  } state_t;
`endif

  state_t state, state_next;

  // Only the first three bytes of a word need storage; the fourth goes straight into dina.
  logic [RAM_WIDTH-BYTE_WIDTH-1:0] word;
  logic [1:0]                      byte_cnt;
  logic                            pending;
  logic [BYTE_WIDTH-1:0]           pend_byte;

  logic                  byte_avail;
  logic [BYTE_WIDTH-1:0] byte_in;
  logic                  consume;
  logic                  overrun;
  logic                  overflow;
  logic                  begin_load;
  logic                  halt_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_WIDTH-1:0] csum;
  logic                  check_bad;
`endif

  // A buffered byte is always older than one arriving now, so it is taken first.
  assign byte_avail = pending | rx_valid;
  assign byte_in    = pending ? pend_byte : rx_data;
  assign halt_word  = (dina[RAM_WIDTH-1 -: 6] == HALT_OPCODE);
  assign wea        = (state == WRITE);
  assign busy       = (state != IDLE) && (state != DONE);

  always_ff @(posedge clka or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    consume    = 1'b0;
    overrun    = 1'b0;
    overflow   = 1'b0;
    begin_load = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    check_bad  = 1'b0;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          begin_load = 1'b1;
          state_next = RECV;
        end
      end
      RECV: begin
        if (byte_avail) begin
          consume = 1'b1;
          if (byte_cnt == 2'd3) state_next = SETUP;
        end
      end
      SETUP, WRITE: begin
        if (pending && rx_valid) begin
          overrun    = 1'b1;
          state_next = DONE;
        end else begin
          state_next = (state == SETUP) ? WRITE : HOLD;
        end
      end
      HOLD: begin
        if (pending && rx_valid) begin
          overrun    = 1'b1;
          state_next = DONE;
        end else if (halt_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end else if (word_count == CW'(RAM_DEPTH)) begin
          overflow   = 1'b1;
          state_next = DONE;
        end else begin
          state_next = RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (byte_avail) begin
          check_bad  = (byte_in != csum);
          state_next = DONE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      addra      <= '0;
      dina       <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      word       <= '0;
      byte_cnt   <= 2'd0;
      pending    <= 1'b0;
      pend_byte  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else if (begin_load) begin
      addra      <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      word       <= '0;
      byte_cnt   <= 2'd0;
      pending    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      if (consume) begin
        word     <= {word[RAM_WIDTH-2*BYTE_WIDTH-1:0], byte_in};
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) dina <= {word, byte_in};
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum     <= csum ^ byte_in;
`endif
      end
      case (state)
        RECV: begin
          // A byte arriving while the buffer drains refills it for the next cycle.
          if (pending) begin
            pending   <= rx_valid;
            pend_byte <= rx_data;
          end
        end
        SETUP, WRITE, HOLD: begin
          if (rx_valid && !pending) begin
            pending   <= 1'b1;
            pend_byte <= rx_data;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: pending <= 1'b0;
`endif
        default: ;
      endcase
      // The word is in the RAM once WRITE has been presented, even if an overrun aborts here.
      if (state == WRITE) word_count <= word_count + CW'(1);
      if (state == HOLD && state_next == RECV) addra <= addra + RAM_WIDTH'(1);
      if (overrun || overflow) error <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (check_bad) error <= 1'b1;
`endif
      if (state_next == DONE && state != DONE) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a default-depth instance and a RAM_DEPTH=4 instance driven by the
// same byte stream, checked against a word-level model of the program load.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [31:0] addra_s [2];
  logic [31:0] dina_s  [2];
  logic        wea_s   [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic        error_s [2];
  logic [11:0] wc0;
  logic [2:0]  wc4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          inst;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t         wr_q[$];
  logic [31:0] words_q[$];
  logic [63:0] exp_q[$];

  logic [31:0] pa [2][3];
  logic [31:0] pd [2][3];
  logic        pw [2][3];

  always #5 clk = ~clk;

  imem_loader dut (
    .clka(clk), .reset(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .addra(addra_s[0]), .dina(dina_s[0]), .wea(wea_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .error(error_s[0]), .word_count(wc0)
  );

  imem_loader #(.RAM_DEPTH(4)) dut4 (
    .clka(clk), .reset(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .addra(addra_s[1]), .dina(dina_s[1]), .wea(wea_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .error(error_s[1]), .word_count(wc4)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // RAM-side observer: logs every write and checks address/data stability around wea.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 2; j++) begin
        pa[k][j] = pa[k][j+1];
        pd[k][j] = pd[k][j+1];
        pw[k][j] = pw[k][j+1];
      end
      pa[k][2] = addra_s[k];
      pd[k][2] = dina_s[k];
      pw[k][2] = wea_s[k];
      if (wea_s[k] === 1'b1) wr_q.push_back('{k, addra_s[k], dina_s[k]});
      if (pw[k][1] === 1'b1) begin
        checks++;
        if (pw[k][0] !== 1'b0 || pw[k][2] !== 1'b0 ||
            pa[k][0] !== pa[k][1] || pa[k][2] !== pa[k][1] ||
            pd[k][0] !== pd[k][1] || pd[k][2] !== pd[k][1]) begin
          errors++;
          $display("FAIL wr_timing inst%0d wea=%b%b%b addr=%h/%h/%h data=%h/%h/%h want wea=010 and stable",
                   k, pw[k][0], pw[k][1], pw[k][2], pa[k][0], pa[k][1], pa[k][2],
                   pd[k][0], pd[k][1], pd[k][2]);
        end
      end
    end
  end

  function automatic int n_wr(input int k);
    int n = 0;
    foreach (wr_q[i]) if (wr_q[i].inst == k) n++;
    return n;
  endfunction

  function automatic logic [63:0] wr_at(input int k, input int idx);
    int n = 0;
    foreach (wr_q[i]) begin
      if (wr_q[i].inst == k) begin
        if (n == idx) return {wr_q[i].a, wr_q[i].d};
        n++;
      end
    end
    return 'x;
  endfunction

  function automatic logic [11:0] wc_of(input int k);
    return (k == 0) ? wc0 : {9'b0, wc4};
  endfunction

  // Word-level model: words land at consecutive addresses until the HALT word or the depth limit.
  task automatic model(input int depth, output bit fin, output bit err);
    exp_q.delete();
    fin = 1'b0;
    err = 1'b0;
    foreach (words_q[i]) begin
      exp_q.push_back({32'(i), words_q[i]});
      if (words_q[i][31:26] == 6'h3F) begin
        fin = 1'b1;
        break;
      end
      if (i + 1 == depth) begin
        fin = 1'b1;
        err = 1'b1;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_words(input int gap, input bit with_cs);
    logic [7:0] cs = 8'h00;
    logic [7:0] b;
    foreach (words_q[i]) begin
      for (int j = 3; j >= 0; j--) begin
        b  = words_q[i][j*8 +: 8];
        cs = cs ^ b;
        send_byte(b, (gap > 0) ? gap : int'($urandom_range(2, 8)));
      end
    end
    if (with_cs) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(cs, 3);
`else
      idle(1);
`endif
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    idle(3);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({addra_s[k], dina_s[k], wea_s[k], busy_s[k], done_s[k], error_s[k], wc_of(k)} !== '0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d addr=%h data=%h wea=%b busy=%b done=%b err=%b wc=%0d want all 0",
                 k, addra_s[k], dina_s[k], wea_s[k], busy_s[k], done_s[k], error_s[k], wc_of(k));
      end
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_normal_load();
    bit fin, err;
    wr_q.delete();
    words_q = '{32'h20010005, 32'hFC000000};
    pulse_start();
    send_words(10, 1'b1);
    idle(12);
    for (int k = 0; k < 2; k++) begin
      model((k == 0) ? 2048 : 4, fin, err);
      checks++;
      if (n_wr(k) != exp_q.size()) begin
        errors++; $display("FAIL normal_nwr inst%0d got %0d want %0d", k, n_wr(k), exp_q.size());
      end
      foreach (exp_q[i]) begin
        checks++;
        if (wr_at(k, i) !== exp_q[i]) begin
          errors++; $display("FAIL normal_write inst%0d #%0d got %h want %h", k, i, wr_at(k, i), exp_q[i]);
        end
      end
      checks++;
      if ({busy_s[k], done_s[k], error_s[k]} !== {!fin, fin, err} || wc_of(k) !== 12'(exp_q.size())) begin
        errors++; $display("FAIL normal_status inst%0d bde=%b%b%b wc=%0d want bde=%b%b%b wc=%0d", k,
                 busy_s[k], done_s[k], error_s[k], wc_of(k), !fin, fin, err, exp_q.size());
      end
    end
  endtask

  task automatic test_pending();
    bit fin, err;
    wr_q.delete();
    words_q = '{32'h12345678, 32'h9ABCDEF0, 32'hFC0000AA};
    pulse_start();
    send_words(2, 1'b1);
    idle(12);
    for (int k = 0; k < 2; k++) begin
      model((k == 0) ? 2048 : 4, fin, err);
      checks++;
      if (n_wr(k) != exp_q.size()) begin
        errors++; $display("FAIL pending_nwr inst%0d got %0d want %0d", k, n_wr(k), exp_q.size());
      end
      foreach (exp_q[i]) begin
        checks++;
        if (wr_at(k, i) !== exp_q[i]) begin
          errors++; $display("FAIL pending_write inst%0d #%0d got %h want %h", k, i, wr_at(k, i), exp_q[i]);
        end
      end
      checks++;
      if ({busy_s[k], done_s[k], error_s[k]} !== {!fin, fin, err} || wc_of(k) !== 12'(exp_q.size())) begin
        errors++; $display("FAIL pending_status inst%0d bde=%b%b%b wc=%0d want bde=%b%b%b wc=%0d", k,
                 busy_s[k], done_s[k], error_s[k], wc_of(k), !fin, fin, err, exp_q.size());
      end
    end
  endtask

  // Bytes every cycle: the buffer absorbs one byte during the write, the next one overruns.
  task automatic test_back_to_back();
    logic [7:0] b [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    wr_q.delete();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(b[i], 1);
    idle(6);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (n_wr(k) != 1 || wr_at(k, 0) !== {32'h0, 32'h12345678}) begin
        errors++; $display("FAIL overrun_writes inst%0d n=%0d first=%h want n=1 first=%h", k,
                 n_wr(k), wr_at(k, 0), {32'h0, 32'h12345678});
      end
      checks++;
      if ({busy_s[k], done_s[k], error_s[k]} !== 3'b011 || wc_of(k) !== 12'd1) begin
        errors++; $display("FAIL overrun_status inst%0d bde=%b%b%b wc=%0d want bde=011 wc=1", k,
                 busy_s[k], done_s[k], error_s[k], wc_of(k));
      end
    end
  endtask

  task automatic test_overflow();
    bit fin, err;
    wr_q.delete();
    words_q = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    pulse_start();
    send_words(3, 1'b0);
    idle(12);
    for (int k = 0; k < 2; k++) begin
      model((k == 0) ? 2048 : 4, fin, err);
      checks++;
      if (n_wr(k) != exp_q.size()) begin
        errors++; $display("FAIL overflow_nwr inst%0d got %0d want %0d", k, n_wr(k), exp_q.size());
      end
      foreach (exp_q[i]) begin
        checks++;
        if (wr_at(k, i) !== exp_q[i]) begin
          errors++; $display("FAIL overflow_write inst%0d #%0d got %h want %h", k, i, wr_at(k, i), exp_q[i]);
        end
      end
      checks++;
      if ({busy_s[k], done_s[k], error_s[k]} !== {!fin, fin, err} || wc_of(k) !== 12'(exp_q.size())) begin
        errors++; $display("FAIL overflow_status inst%0d bde=%b%b%b wc=%0d want bde=%b%b%b wc=%0d", k,
                 busy_s[k], done_s[k], error_s[k], wc_of(k), !fin, fin, err, exp_q.size());
      end
    end
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_reset_mid_word();
    bit fin, err;
    wr_q.delete();
    pulse_start();
    send_byte(8'h11, 3);
    send_byte(8'h22, 3);
    rst = 1'b1;
    idle(1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({addra_s[k], dina_s[k], wea_s[k], busy_s[k], done_s[k], error_s[k], wc_of(k)} !== '0) begin
        errors++;
        $display("FAIL midreset_outputs inst%0d addr=%h data=%h wea=%b busy=%b done=%b err=%b wc=%0d want all 0",
                 k, addra_s[k], dina_s[k], wea_s[k], busy_s[k], done_s[k], error_s[k], wc_of(k));
      end
    end
    rst = 1'b0;
    idle(2);
    words_q = '{32'hFC000000};
    pulse_start();
    send_words(3, 1'b1);
    idle(12);
    for (int k = 0; k < 2; k++) begin
      model((k == 0) ? 2048 : 4, fin, err);
      checks++;
      if (n_wr(k) != exp_q.size() || wr_at(k, 0) !== exp_q[0]) begin
        errors++; $display("FAIL midreset_write inst%0d n=%0d first=%h want n=%0d first=%h", k,
                 n_wr(k), wr_at(k, 0), exp_q.size(), exp_q[0]);
      end
      checks++;
      if ({busy_s[k], done_s[k], error_s[k]} !== {!fin, fin, err} || wc_of(k) !== 12'(exp_q.size())) begin
        errors++; $display("FAIL midreset_status inst%0d bde=%b%b%b wc=%0d want bde=%b%b%b wc=%0d", k,
                 busy_s[k], done_s[k], error_s[k], wc_of(k), !fin, fin, err, exp_q.size());
      end
    end
  endtask

  task automatic test_random();
    bit fin, err;
    logic [31:0] w;
    int n;
    for (int it = 0; it < 6; it++) begin
      wr_q.delete();
      words_q.delete();
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n - 1; i++) begin
        w = $urandom;
        if (w[31:26] == 6'h3F) w[31] = 1'b0;
        words_q.push_back(w);
      end
      words_q.push_back({6'h3F, 26'($urandom)});
      pulse_start();
      send_words(0, 1'b1);
      idle(12);
      for (int k = 0; k < 2; k++) begin
        model((k == 0) ? 2048 : 4, fin, err);
        checks++;
        if (n_wr(k) != exp_q.size()) begin
          errors++; $display("FAIL random%0d_nwr inst%0d got %0d want %0d", it, k, n_wr(k), exp_q.size());
        end
        foreach (exp_q[i]) begin
          checks++;
          if (wr_at(k, i) !== exp_q[i]) begin
            errors++; $display("FAIL random%0d_write inst%0d #%0d got %h want %h", it, k, i, wr_at(k, i), exp_q[i]);
          end
        end
        checks++;
        if ({busy_s[k], done_s[k], error_s[k]} !== {!fin, fin, err} || wc_of(k) !== 12'(exp_q.size())) begin
          errors++; $display("FAIL random%0d_status inst%0d bde=%b%b%b wc=%0d want bde=%b%b%b wc=%0d", it, k,
                   busy_s[k], done_s[k], error_s[k], wc_of(k), !fin, fin, err, exp_q.size());
        end
      end
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    words_q = '{32'hFC000000};
    for (int bad = 0; bad < 2; bad++) begin
      pulse_start();
      if (bad == 0) begin
        send_words(3, 1'b1);
      end else begin
        send_words(3, 1'b0);
        send_byte(8'h00, 3);
      end
      idle(8);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({busy_s[k], done_s[k], error_s[k]} !== {2'b01, (bad == 1)}) begin
          errors++; $display("FAIL checksum%0d_status inst%0d bde=%b%b%b want bde=01%0d", bad, k,
                   busy_s[k], done_s[k], error_s[k], bad);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_normal_load();
    test_pending();
    test_back_to_back();
    test_overflow();
    test_reset_mid_word();
    test_random();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
